// File: rtl/monitor_host.sv
// Host-side initiator for the robin serial monitor protocol.
// Sends a 6-byte header, checks echoes, streams load data or forwards dump data.
module monitor_host #(
  parameter int unsigned TIMEOUT_WIDTH = 20,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_TX,
    S_HDR_ECHO,
    S_LD_FETCH,
    S_LD_TX,
    S_LD_ECHO,
    S_DUMP_RX,
    S_FIN
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_DUMP = 2'd2;

  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE =
    {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        rdv_q, rdv_d;
  logic [7:0]  rdd_q, rdd_d;

  logic [7:0]  hdr_byte;
  logic        wd_expired;

  // Header byte currently addressed by the index.
  always_comb begin
    hdr_byte = len_q[7:0];
    unique case (idx_q)
      3'd0:    hdr_byte = {6'd0, op_q};
      3'd1:    hdr_byte = addr_q[23:16];
      3'd2:    hdr_byte = addr_q[15:8];
      3'd3:    hdr_byte = addr_q[7:0];
      3'd4:    hdr_byte = len_q[15:8];
      default: hdr_byte = len_q[7:0];
    endcase
  end

  assign wd_expired = (wdog_q <= WD_ONE);

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    code_d    = code_q;
    rdv_d     = 1'b0;
    rdd_d     = rdd_q;
    cmd_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    wr_ready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = reset_n;
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          len_d  = cmd_len;
          idx_d  = 3'd0;
          err_d  = 1'b0;
          code_d = 2'd0;
          if (cmd_op == 2'd0) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = S_FIN;
          end else begin
            state_d = S_HDR_TX;
          end
        end
      end
      S_HDR_TX: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        if (tx_ready) begin
          wdog_d  = TIMEOUT;
          state_d = S_HDR_ECHO;
        end
      end
      S_HDR_ECHO: begin
        if (rx_valid) begin
          if (rx_data == hdr_byte) begin
            idx_d = idx_q + 3'd1;
            if (idx_q != 3'd5) begin
              state_d = S_HDR_TX;
            end else if (op_q == OP_LOAD && len_q != 16'd0) begin
              state_d = S_LD_FETCH;
            end else if (op_q == OP_DUMP && len_q != 16'd0) begin
              wdog_d  = TIMEOUT;
              state_d = S_DUMP_RX;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_FIN;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_FIN;
        end else begin
          wdog_d = wdog_q - WD_ONE;
        end
      end
      S_LD_FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          byte_d  = wr_data;
          state_d = S_LD_TX;
        end
      end
      S_LD_TX: begin
        tx_valid = 1'b1;
        tx_data  = byte_q;
        if (tx_ready) begin
          wdog_d  = TIMEOUT;
          state_d = S_LD_ECHO;
        end
      end
      S_LD_ECHO: begin
        if (rx_valid) begin
          if (rx_data == byte_q) begin
            len_d   = len_q - 16'd1;
            state_d = (len_q == 16'd1) ? S_FIN : S_LD_FETCH;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_FIN;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_FIN;
        end else begin
          wdog_d = wdog_q - WD_ONE;
        end
      end
      S_DUMP_RX: begin
        if (rx_valid) begin
          rdv_d  = 1'b1;
          rdd_d  = rx_data;
          len_d  = len_q - 16'd1;
          wdog_d = TIMEOUT;
          if (len_q == 16'd1) begin
            state_d = S_FIN;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_FIN;
        end else begin
          wdog_d = wdog_q - WD_ONE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      addr_q  <= 24'd0;
      len_q   <= 16'd0;
      idx_q   <= 3'd0;
      byte_q  <= 8'h00;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      rdv_q   <= 1'b0;
      rdd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      code_q  <= code_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign error    = err_q;
  assign err_code = code_q;
  assign rd_valid = rdv_q;
  assign rd_data  = rdd_q;

endmodule

// File: tb/tb_monitor_host.sv
// Directed scoreboard bench for monitor_host.
// Acts as the remote monitor: echoes bytes and supplies dump data.
module tb_monitor_host;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  monitor_host #(
    .TIMEOUT_WIDTH(20),
    .TIMEOUT(20'd16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code)
  );

  int errs = 0;
  int checks = 0;
  int tx_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] rdq[$];
  logic [7:0] wrq[$];
  logic [7:0] dumpq[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare every tx and rd byte against the queues.
  always @(negedge clk) begin
    if (reset_n && tx_valid && tx_ready) begin
      tx_cnt++;
      if (txq.size() == 0) check("tx_extra", 32'(txq.size()), 32'd1);
      else check("tx_byte", {24'd0, tx_data}, {24'd0, txq.pop_front()});
    end
    if (reset_n && rd_valid) begin
      rd_cnt++;
      if (rdq.size() == 0) check("rd_extra", 32'(rdq.size()), 32'd1);
      else check("rd_byte", {24'd0, rd_data}, {24'd0, rdq.pop_front()});
    end
    if (reset_n && wr_valid && wr_ready) wr_cnt++;
  end

  task automatic push_hdr(input logic [1:0] op, input logic [23:0] a,
                          input logic [15:0] l);
    txq.push_back({6'd0, op});
    txq.push_back(a[23:16]);
    txq.push_back(a[15:8]);
    txq.push_back(a[7:0]);
    txq.push_back(l[15:8]);
    txq.push_back(l[7:0]);
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] a,
                       input logic [15:0] l);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  // Remote monitor model: echo each sent byte, feed payload and dump data.
  task automatic serve(input int budget, input int bad_idx,
                       input logic [7:0] bad_val, input int dump_n,
                       input bit want_done, output int done_cyc,
                       output int last_rx_cyc);
    int cyc = 0;
    int sent = 0;
    int fed = 0;
    bit pend = 1'b0;
    bit tog = 1'b0;
    bit seen = 1'b0;
    logic [7:0] lb = 8'h00;
    done_cyc = -1;
    last_rx_cyc = -1;
    while (cyc < budget && !seen) begin
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      wr_valid = 1'b0;
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end else begin
        if (pend) begin
          rx_valid = 1'b1;
          rx_data  = (sent - 1 == bad_idx) ? bad_val : lb;
          pend = 1'b0;
          last_rx_cyc = cyc;
        end else if (tx_valid) begin
          tx_ready = 1'b1;
          lb = tx_data;
          sent++;
          pend = 1'b1;
        end else if (sent >= 6 && fed < dump_n && dumpq.size() > 0) begin
          tog = !tog;
          if (tog) begin
            rx_valid = 1'b1;
            rx_data  = dumpq.pop_front();
            rdq.push_back(rx_data);
            fed++;
            last_rx_cyc = cyc;
          end
        end
        if (wr_ready && wrq.size() > 0) begin
          wr_valid = 1'b1;
          wr_data  = wrq.pop_front();
        end
        step();
        cyc++;
      end
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    wr_valid = 1'b0;
    if (want_done) check("done_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int dc;
    int lr;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 24'd0;
    cmd_len   = 16'd0;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    step();
    step();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    rx_valid = 1'b1;
    rx_data  = 8'h55;
    step();
    rx_valid = 1'b0;
    check("idle_rx_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("idle_rx_busy", {31'd0, busy}, 32'd0);

    // Exec
    tx_cnt = 0;
    push_hdr(2'd3, 24'h002000, 16'd0);
    issue(2'd3, 24'h002000, 16'd0);
    check("exec_first_tx", {31'd0, tx_valid}, 32'd1);
    check("exec_busy", {31'd0, busy}, 32'd1);
    serve(200, -1, 8'h00, 0, 1'b1, dc, lr);
    check("exec_done_lat", 32'(dc - lr), 32'd1);
    check("exec_error", {31'd0, error}, 32'd0);
    check("exec_code", {30'd0, err_code}, 32'd0);
    check("exec_tx_cnt", 32'(tx_cnt), 32'd6);
    step();
    check("exec_done_pulse", {31'd0, done}, 32'd0);
    check("exec_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Load
    tx_cnt = 0;
    wr_cnt = 0;
    push_hdr(2'd1, 24'h000100, 16'd3);
    txq.push_back(8'hA5);
    txq.push_back(8'h5A);
    txq.push_back(8'hFF);
    wrq.push_back(8'hA5);
    wrq.push_back(8'h5A);
    wrq.push_back(8'hFF);
    issue(2'd1, 24'h000100, 16'd3);
    serve(400, -1, 8'h00, 0, 1'b1, dc, lr);
    check("load_done_lat", 32'(dc - lr), 32'd1);
    check("load_error", {31'd0, error}, 32'd0);
    check("load_wr_cnt", 32'(wr_cnt), 32'd3);
    check("load_tx_cnt", 32'(tx_cnt), 32'd9);
    check("load_txq_left", 32'(txq.size()), 32'd0);
    step();

    // Dump
    rd_cnt = 0;
    push_hdr(2'd2, 24'h020000, 16'd4);
    dumpq.push_back(8'h11);
    dumpq.push_back(8'h22);
    dumpq.push_back(8'h33);
    dumpq.push_back(8'h44);
    issue(2'd2, 24'h020000, 16'd4);
    serve(400, -1, 8'h00, 4, 1'b1, dc, lr);
    check("dump_rd_with_done", {31'd0, rd_valid}, 32'd1);
    check("dump_done_lat", 32'(dc - lr), 32'd1);
    check("dump_error", {31'd0, error}, 32'd0);
    step();
    check("dump_rd_cnt", 32'(rd_cnt), 32'd4);
    check("dump_rdq_left", 32'(rdq.size()), 32'd0);

    // Echo mismatch on the 4th header byte
    tx_cnt = 0;
    push_hdr(2'd1, 24'h000100, 16'd3);
    void'(txq.pop_back());
    void'(txq.pop_back());
    issue(2'd1, 24'h000100, 16'd3);
    serve(200, 3, 8'h7E, 0, 1'b1, dc, lr);
    check("mm_error", {31'd0, error}, 32'd1);
    check("mm_code", {30'd0, err_code}, 32'd1);
    step();
    step();
    step();
    check("mm_tx_cnt", 32'(tx_cnt), 32'd4);
    check("mm_error_held", {31'd0, error}, 32'd1);

    // Timeout: dump of 2 with one byte supplied
    rd_cnt = 0;
    push_hdr(2'd2, 24'h000040, 16'd2);
    dumpq.push_back(8'hC3);
    dumpq.push_back(8'h3C);
    issue(2'd2, 24'h000040, 16'd2);
    serve(200, -1, 8'h00, 1, 1'b1, dc, lr);
    check("to_window", {31'd0, (dc - lr >= 16) && (dc - lr <= 17)}, 32'd1);
    check("to_error", {31'd0, error}, 32'd1);
    check("to_code", {30'd0, err_code}, 32'd2);
    step();
    check("to_rd_cnt", 32'(rd_cnt), 32'd1);
    dumpq.delete();

    // Reset in the middle of a load
    push_hdr(2'd1, 24'h000100, 16'd3);
    wrq.push_back(8'hA5);
    issue(2'd1, 24'h000100, 16'd3);
    serve(5, -1, 8'h00, 0, 1'b0, dc, lr);
    reset_n = 1'b0;
    step();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    txq.delete();
    wrq.delete();
    reset_n = 1'b1;
    step();
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Illegal op
    tx_cnt = 0;
    issue(2'd0, 24'h123456, 16'd9);
    check("ill_done", {31'd0, done}, 32'd1);
    check("ill_error", {31'd0, error}, 32'd1);
    check("ill_code", {30'd0, err_code}, 32'd3);
    check("ill_tx_valid", {31'd0, tx_valid}, 32'd0);
    step();
    step();
    check("ill_tx_cnt", 32'(tx_cnt), 32'd0);
    check("ill_ready", {31'd0, cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
